// File: rtl/mul_chain_sched.sv
// rtl/mul_chain_sched.sv - round-robin scheduler sharing one chained FP32 multiplier
//
// Purpose:
//   NUM_REQ requesters each submit a product job of (len+1) FP32 operands. The
//   scheduler picks a winner round-robin, buffers its operands, streams them
//   into a shared mul_one-style chained multiplier and returns the tagged
//   result. A len=0 job bypasses the multiplier and returns its single operand.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, req_len     per-requester job request level and multiply count (3b each)
//   gnt              one-hot grant, held for the whole job
//   op_stb, op_data  per-requester operand valid / word (32b each)
//   op_ack           operand accept, only the granted bit can assert
//   res_stb/res_ack  result handshake; res_data product, res_id requester id
//   mul_stb, mul_ack first-operand strobe / operand-sample indication
//   mul_data         operand to the multiplier (valid throughout ISSUE)
//   cnt_max          multiply count for the current job
//   output_z_ack     result accept to the multiplier
//   s_output_z_stb   multiplier result valid; s_output_z multiplier result

module mul_chain_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [3*NUM_REQ-1:0]    req_len,
  output logic [NUM_REQ-1:0]      gnt,
  input  logic [NUM_REQ-1:0]      op_stb,
  input  logic [32*NUM_REQ-1:0]   op_data,
  output logic [NUM_REQ-1:0]      op_ack,
  output logic                    res_stb,
  output logic [31:0]             res_data,
  output logic [IDW-1:0]          res_id,
  input  logic                    res_ack,
  output logic                    mul_stb,
  input  logic                    mul_ack,
  output logic [31:0]             mul_data,
  output logic [2:0]              cnt_max,
  output logic                    output_z_ack,
  input  logic                    s_output_z_stb,
  input  logic [31:0]             s_output_z
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [2:0]     len_q;
  logic [3:0]     wr_ptr;
  logic [3:0]     rd_ptr;
  logic           stb_done;
  logic [31:0]    op_buf [8];

  // Arbitration: first requester at or after rr_ptr, wrapping.
  logic           found;
  logic [IDW-1:0] win_id;
  logic [2:0]     win_len;
  logic [IDW:0]   sum;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && req[sum[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_len = 3'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_id == IDW'(j)) win_len = req_len[3*j +: 3];
    end
  end

  // Granted requester's operand lane, selected by the one-hot grant.
  logic        cur_stb;
  logic [31:0] cur_data;

  always_comb begin
    cur_stb  = 1'b0;
    cur_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) begin
        cur_stb  = op_stb[j];
        cur_data = op_data[32*j +: 32];
      end
    end
  end

  logic load_fire;
  logic last_word;

  assign load_fire    = (state == S_LOAD) && cur_stb;
  assign last_word    = (wr_ptr == {1'b0, len_q});
  assign op_ack       = (state == S_LOAD) ? gnt : '0;
  assign mul_stb      = (state == S_ISSUE) && !stb_done;
  // The multiplier samples follow-on operands on mul_ack alone, so the word at
  // rd_ptr is presented for the whole of ISSUE; gated to 0 elsewhere because
  // the buffer itself is never cleared.
  assign mul_data     = (state == S_ISSUE) ? op_buf[rd_ptr[2:0]] : '0;
  assign cnt_max      = len_q;
  assign output_z_ack = (state == S_WAIT_Z);
  assign res_stb      = (state == S_RESP);
  assign res_id       = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      id_q     <= '0;
      len_q    <= 3'd0;
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      stb_done <= 1'b0;
      res_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt    <= NUM_REQ'(1) << win_id;
            id_q   <= win_id;
            len_q  <= win_len;
            rr_ptr <= (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
            wr_ptr <= 4'd0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            wr_ptr <= wr_ptr + 4'd1;
            if (last_word) begin
              if (len_q == 3'd0) begin
                // Single-operand job: the product is the operand itself.
                res_data <= cur_data;
                state    <= S_RESP;
              end else begin
                rd_ptr   <= 4'd0;
                stb_done <= 1'b0;
                state    <= S_ISSUE;
              end
            end
          end
        end
        S_ISSUE: begin
          if (mul_ack) begin
            stb_done <= 1'b1;
            rd_ptr   <= rd_ptr + 4'd1;
            if (rd_ptr == {1'b0, len_q}) state <= S_WAIT_Z;
          end
        end
        S_WAIT_Z: begin
          if (s_output_z_stb) begin
            res_data <= s_output_z;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ack) begin
            gnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand buffer has no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (load_fire) op_buf[wr_ptr[2:0]] <= cur_data;
  end

endmodule

// File: tb/tb_mul_chain_sched.sv
// tb/tb_mul_chain_sched.sv - directed self-checking bench for mul_chain_sched

module tb_mul_chain_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_len;
  logic [3:0]  gnt;
  logic [3:0]  op_stb;
  logic [127:0] op_data;
  logic [3:0]  op_ack;
  logic        res_stb;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic        res_ack;
  logic        mul_stb;
  logic        mul_ack;
  logic [31:0] mul_data;
  logic [2:0]  cnt_max;
  logic        output_z_ack;
  logic        s_output_z_stb;
  logic [31:0] s_output_z;

  int checks = 0;
  int errors = 0;

  logic [31:0] ops_v [8];
  logic [31:0] mz_result;
  bit          mul_gap;
  bit          stray_z;

  // Multiplier model state
  int          mphase;
  int          dly;
  int          cap_n;
  int          mul_stb_seen;
  logic [31:0] cap [8];
  logic [2:0]  cnt_first;
  bit          cnt_bad;

  always #5 clk = ~clk;

  mul_chain_sched #(.NUM_REQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
    .op_stb(op_stb), .op_data(op_data), .op_ack(op_ack),
    .res_stb(res_stb), .res_data(res_data), .res_id(res_id), .res_ack(res_ack),
    .mul_stb(mul_stb), .mul_ack(mul_ack), .mul_data(mul_data), .cnt_max(cnt_max),
    .output_z_ack(output_z_ack), .s_output_z_stb(s_output_z_stb), .s_output_z(s_output_z)
  );

  // Chained multiplier model: acks the first operand on mul_stb, then keeps
  // acking (optionally every other cycle) until cnt_max+1 words are captured,
  // then returns mz_result a few cycles later.
  initial begin
    mul_ack = 1'b0; s_output_z_stb = 1'b0; s_output_z = '0;
    mphase = 0; dly = 0; cap_n = 0; mul_stb_seen = 0; cnt_first = 3'd0; cnt_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mul_ack = 1'b0; s_output_z_stb = 1'b0; mphase = 0;
      end else begin
        if (mul_stb) mul_stb_seen++;
        case (mphase)
          0: begin
            mul_ack = 1'b0;
            s_output_z_stb = stray_z;
            s_output_z = stray_z ? 32'hDEADBEEF : 32'h0;
            if (mul_stb) begin
              s_output_z_stb = 1'b0;
              cnt_first = cnt_max; cnt_bad = 1'b0;
              cap[0] = mul_data; cap_n = 1;
              mul_ack = 1'b1; mphase = 1;
            end
          end
          1: begin
            if (cnt_max !== cnt_first) cnt_bad = 1'b1;
            if (cap_n > int'(cnt_first)) begin
              mul_ack = 1'b0; dly = 3; mphase = 2;
            end else if (mul_gap && mul_ack) begin
              mul_ack = 1'b0;
            end else begin
              cap[cap_n] = mul_data; cap_n++; mul_ack = 1'b1;
            end
          end
          2: begin
            if (dly > 0) dly--;
            else begin
              s_output_z = mz_result; s_output_z_stb = 1'b1; mphase = 3;
            end
          end
          default: begin
            s_output_z_stb = 1'b0; mphase = 0;
          end
        endcase
      end
    end
  end

  task automatic wait_grant(input int id, output bit ok);
    int t;
    t = 0;
    while (gnt[id] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    ok = (t < 100);
  endtask

  task automatic wait_res(output bit ok);
    int t;
    t = 0;
    while (res_stb !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    ok = (t < 500);
  endtask

  task automatic load_ops(input int id, input int len, input bit gaps, output bit ok);
    ok = 1'b1;
    for (int w = 0; w <= len; w++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin @(negedge clk); op_stb[id] = 1'b0; end
      end
      @(negedge clk);
      op_stb[id] = 1'b1;
      op_data[32*id +: 32] = ops_v[w];
      begin
        int t;
        t = 0;
        while (op_ack[id] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) ok = 1'b0;
      end
    end
    @(negedge clk);
    op_stb[id] = 1'b0;
  endtask

  task automatic ack_res;
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, op_ack, res_stb, res_id, mul_stb, cnt_max, output_z_ack} !== 16'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 0", {gnt, op_ack, res_stb, res_id, mul_stb, cnt_max, output_z_ack});
    end
    checks++;
    if (res_data !== 32'h0 || mul_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: res_data %h mul_data %h want 0", res_data, mul_data);
    end
    repeat (2) @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_idle_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_single;
    bit ok1, ok2, ok3;
    ops_v[0] = 32'h40000000; ops_v[1] = 32'h40400000;
    mz_result = 32'h40C00000; mul_gap = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; req_len[2:0] = 3'd1;
    wait_grant(0, ok1);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    req[0] = 1'b0;  // dropping req mid-job must not abort it
    load_ops(0, 1, 1'b0, ok2);
    wait_res(ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL single_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    checks++;
    if (res_data !== 32'h40C00000) begin errors++; $display("FAIL single_data: got %h want 40c00000", res_data); end
    checks++;
    if (res_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", res_id); end
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_held: got %b want 0001", gnt); end
    checks++;
    if (cap_n !== 2 || cap[0] !== 32'h40000000 || cap[1] !== 32'h40400000) begin
      errors++;
      $display("FAIL single_ops: got n=%0d %h %h want n=2 40000000 40400000", cap_n, cap[0], cap[1]);
    end
    checks++;
    if (cnt_first !== 3'd1 || cnt_bad) begin
      errors++; $display("FAIL single_cnt_max: got %0d changed=%0d want 1 stable", cnt_first, cnt_bad);
    end
    ack_res;
    checks++;
    if (res_stb !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL single_release: res_stb %b gnt %b want 0 0000", res_stb, gnt);
    end
  endtask

  task automatic test_chain;
    bit ok1, ok2, ok3;
    ops_v[0] = 32'h3FC00000; ops_v[1] = 32'h40000000;
    ops_v[2] = 32'h40000000; ops_v[3] = 32'h40000000;
    mz_result = 32'h41400000; mul_gap = 1'b1;
    @(negedge clk);
    req[1] = 1'b1; req_len[5:3] = 3'd3;
    wait_grant(1, ok1);
    load_ops(1, 3, 1'b0, ok2);
    wait_res(ok3);
    req[1] = 1'b0;
    checks++;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL chain_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    checks++;
    if (res_data !== 32'h41400000) begin errors++; $display("FAIL chain_data: got %h want 41400000", res_data); end
    checks++;
    if (res_id !== 2'd1) begin errors++; $display("FAIL chain_id: got %0d want 1", res_id); end
    checks++;
    if (cap_n !== 4) begin errors++; $display("FAIL chain_op_count: got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== ops_v[i]) begin errors++; $display("FAIL chain_op%0d: got %h want %h", i, cap[i], ops_v[i]); end
    end
    checks++;
    if (cnt_first !== 3'd3 || cnt_bad) begin
      errors++; $display("FAIL chain_cnt_max: got %0d changed=%0d want 3 stable", cnt_first, cnt_bad);
    end
    ack_res;
    mul_gap = 1'b0;
  endtask

  task automatic test_bypass;
    bit ok1, ok2, ok3;
    int snap;
    ops_v[0] = 32'h3F800000;
    snap = mul_stb_seen;
    stray_z = 1'b1;  // result strobes outside WAIT_Z must be ignored
    @(negedge clk);
    req[3] = 1'b1; req_len[11:9] = 3'd0;
    wait_grant(3, ok1);
    req[3] = 1'b0;
    load_ops(3, 0, 1'b0, ok2);
    wait_res(ok3);
    stray_z = 1'b0;
    checks++;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL bypass_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    checks++;
    if (res_data !== 32'h3F800000) begin errors++; $display("FAIL bypass_data: got %h want 3f800000", res_data); end
    checks++;
    if (res_id !== 2'd3) begin errors++; $display("FAIL bypass_id: got %0d want 3", res_id); end
    checks++;
    if (mul_stb_seen !== snap) begin errors++; $display("FAIL bypass_mul_stb: got %0d strobes want 0", mul_stb_seen - snap); end
    ack_res;
  endtask

  task automatic test_round_robin;
    int exp_id [7];
    int got;
    int t;
    exp_id = '{0, 2, 0, 2, 0, 1, 0};
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0101; req_len = 12'h0; op_stb = 4'b1111;
    for (int i = 0; i < 4; i++) op_data[32*i +: 32] = 32'h10000000 | i;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 7; n++) begin
      bit ok;
      if (n == 4) req = 4'b0011;
      t = 0;
      while (gnt === 4'b0000 && t < 100) begin @(negedge clk); t++; end
      got = -1;
      for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) got = i;
      checks++;
      if (got !== exp_id[n]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", n, got, exp_id[n]); end
      checks++;
      if ((op_ack & ~gnt) !== 4'b0000) begin errors++; $display("FAIL rr_stray_ack%0d: got %b want 0000", n, op_ack & ~gnt); end
      wait_res(ok);
      checks++;
      if (!ok || res_data !== (32'h10000000 | exp_id[n])) begin
        errors++; $display("FAIL rr_data%0d: got %h want %h", n, res_data, 32'h10000000 | exp_id[n]);
      end
      ack_res;
    end
    req = 4'b0000;
    op_stb = 4'b0000;
  endtask

  task automatic test_backpressure;
    bit ok1, ok2, ok3, stable;
    logic [31:0] d;
    logic [1:0]  rid;
    ops_v[0] = 32'h3F800000; ops_v[1] = 32'h40000000; ops_v[2] = 32'h40800000;
    mz_result = 32'h41000000; mul_gap = 1'b0;
    @(negedge clk);
    req_len = {3'd0, 3'd2, 3'd0, 3'd0};
    req = 4'b0101;
    wait_grant(2, ok1);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_gnt: got %b want 0100", gnt); end
    load_ops(2, 2, 1'b1, ok2);
    wait_res(ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL bp_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    d = res_data; rid = res_id; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_stb !== 1'b1 || res_data !== d || res_id !== rid || gnt !== 4'b0100) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable: got changes want stable hold"); end
    checks++;
    if (d !== 32'h41000000 || rid !== 2'd2) begin errors++; $display("FAIL bp_result: got %h id %0d want 41000000 id 2", d, rid); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== ops_v[i]) begin errors++; $display("FAIL bp_op%0d: got %h want %h", i, cap[i], ops_v[i]); end
    end
    ack_res;
    req = 4'b0000;
    checks++;
    if (res_stb !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL bp_release: res_stb %b gnt %b want 0 0000", res_stb, gnt);
    end
  endtask

  task automatic test_reset_mid_job;
    bit ok1, ok2, ok3;
    int snap;
    int t;
    for (int i = 0; i < 8; i++) ops_v[i] = 32'h3F800000 + i;
    mul_gap = 1'b1;
    snap = mul_stb_seen;
    @(negedge clk);
    req[3] = 1'b1; req_len[11:9] = 3'd7;
    wait_grant(3, ok1);
    load_ops(3, 7, 1'b0, ok2);
    t = 0;
    while (mul_stb_seen == snap && t < 50) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    checks++;
    if (!(ok1 && ok2) || t >= 50 || cnt_max !== 3'd7) begin
      errors++; $display("FAIL rst_job_issue: cnt_max %0d want 7 in ISSUE", cnt_max);
    end
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    checks++;
    if ({gnt, op_ack, res_stb, res_id, mul_stb, cnt_max, output_z_ack} !== 16'h0) begin
      errors++;
      $display("FAIL rst_job_ctrl: got %h want 0", {gnt, op_ack, res_stb, res_id, mul_stb, cnt_max, output_z_ack});
    end
    checks++;
    if (res_data !== 32'h0 || mul_data !== 32'h0) begin
      errors++; $display("FAIL rst_job_data: res_data %h mul_data %h want 0", res_data, mul_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mul_gap = 1'b0;
    ops_v[0] = 32'h40000000; ops_v[1] = 32'h40400000;
    mz_result = 32'h40C00000;
    @(negedge clk);
    req[0] = 1'b1; req_len[2:0] = 3'd1;
    wait_grant(0, ok1);
    load_ops(0, 1, 1'b0, ok2);
    wait_res(ok3);
    req[0] = 1'b0;
    checks++;
    if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL rst_new_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
    checks++;
    if (res_data !== 32'h40C00000 || res_id !== 2'd0) begin
      errors++; $display("FAIL rst_new_result: got %h id %0d want 40c00000 id 0", res_data, res_id);
    end
    checks++;
    if (cap_n !== 2 || cap[0] !== 32'h40000000 || cap[1] !== 32'h40400000) begin
      errors++; $display("FAIL rst_new_ops: got n=%0d %h %h want n=2 40000000 40400000", cap_n, cap[0], cap[1]);
    end
    ack_res;
  endtask

  initial begin
    rst_n = 1'b1; req = '0; req_len = '0; op_stb = '0; op_data = '0; res_ack = 1'b0;
    mul_gap = 1'b0; stray_z = 1'b0; mz_result = '0;
    for (int i = 0; i < 8; i++) ops_v[i] = '0;
    test_reset;
    test_single;
    test_chain;
    test_bypass;
    test_round_robin;
    test_backpressure;
    test_reset_mid_job;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
